// File: rtl/subtree_rr_arbiter_if.sv
// subtree_rr_arbiter_if: request/grant bundle between the five subtree children and their arbiter.
interface subtree_rr_arbiter_if #(
    parameter int N    = 5,
    parameter int IDXW = $clog2(N)
);
    logic [N-1:0]    req;
    logic [N-1:0]    done;
    logic [N-1:0]    gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            busy;
    logic            timeout;
    modport master (output req, done, input gnt, gnt_idx, busy, timeout);
    modport slave  (input req, done, output gnt, gnt_idx, busy, timeout);
endinterface

// File: rtl/subtree_rr_arbiter.sv
// subtree_rr_arbiter: round-robin one-hot grant of a shared resource among N children,
// with a hold-time limit and a one-cycle turnaround gap between owners.
module subtree_rr_arbiter #(
    parameter int N        = 5,
    parameter int MAX_HOLD = 16,
    parameter int IDXW     = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    subtree_rr_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IDXW-1:0] idx_q, idx_d, last_q, last_d, sel;
    logic [7:0]      cnt_q, cnt_d;
    logic            timeout_q, timeout_d, found, rel, lim;

    // Scan starts just after the previous owner, so it gets lowest priority next time.
    always_comb begin
        logic [IDXW-1:0] cand;
        cand  = '0;
        sel   = last_q;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = IDXW'((int'(last_q) + k) % N);
            if (!found && bus.req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    assign rel = bus.done[idx_q] | ~bus.req[idx_q];
    assign lim = cnt_q == 8'(MAX_HOLD - 1);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: if (found) begin
                state_d = GRANT;
                gnt_d   = N'(1) << sel;
                idx_d   = sel;
                last_d  = sel;
                cnt_d   = '0;
            end
            GRANT: begin
                cnt_d = lim ? cnt_q : cnt_q + 8'd1;
                // A normal release wins over the limit, so timeout only fires when nothing else released.
                if (rel || lim) begin
                    state_d   = GAP;
                    gnt_d     = '0;
                    idx_d     = '0;
                    timeout_d = !rel;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            last_q    <= IDXW'(N - 1);
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = idx_q;
    assign bus.busy    = state_q != IDLE;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_subtree_rr_arbiter.sv
// tb_subtree_rr_arbiter: directed scenarios plus random traffic against a behavioural
// ownership model (owner / hold age / cooldown) checked every cycle.
module tb_subtree_rr_arbiter;
    localparam int N = 5;
    localparam int MAX_HOLD = 16;

    logic clk;
    logic rst_n;
    int   n_chk = 0;
    int   n_pass = 0;

    subtree_rr_arbiter_if #(.N(N)) b ();
    subtree_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (.clk(clk), .rst_n(rst_n), .bus(b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: who owns the resource, how many cycles it has held it, and how long until a new grant may start.
    int m_own = -1;
    int m_age = 0;
    int m_cool = 0;
    int m_last = N - 1;
    int m_to = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_own = -1; m_age = 0; m_cool = 0; m_last = N - 1; m_to = 0;
        end else begin
            m_to = 0;
            if (m_own >= 0) begin
                if (b.done[m_own] || !b.req[m_own]) begin
                    m_own = -1; m_cool = 1;
                end else if (m_age == MAX_HOLD) begin
                    m_own = -1; m_cool = 1; m_to = 1;
                end else m_age++;
            end else if (m_cool > 0) m_cool--;
            else begin
                for (int k = 1; k <= N; k++)
                    if (m_own < 0 && b.req[(m_last + k) % N]) m_own = (m_last + k) % N;
                if (m_own >= 0) begin
                    m_last = m_own; m_age = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_gnt", int'(b.gnt), m_own < 0 ? 0 : (1 << m_own));
            chk("model_idx", int'(b.gnt_idx), m_own < 0 ? 0 : m_own);
            chk("model_busy", int'(b.busy), (m_own >= 0 || m_cool > 0) ? 1 : 0);
            chk("model_timeout", int'(b.timeout), m_to);
        end
    end

    task automatic do_reset();
        b.req = '0; b.done = '0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int order[$];
        int gaps[$];
        int age, gap, hi, to_cnt, to_at_fall, packed_order;
        bit fell;
        rst_n = 1'b0; b.req = '0; b.done = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", int'(b.gnt), 0);
        chk("rst_idx", int'(b.gnt_idx), 0);
        chk("rst_busy", int'(b.busy), 0);
        chk("rst_timeout", int'(b.timeout), 0);
        rst_n = 1'b1;
        tick();

        // single requester, done on third grant cycle
        b.req = 5'b00100;
        tick();
        chk("single_gnt", int'(b.gnt), 5'b00100);
        chk("single_idx", int'(b.gnt_idx), 2);
        chk("single_busy", int'(b.busy), 1);
        tick(); tick();
        chk("single_gnt_c3", int'(b.gnt), 5'b00100);
        b.done = 5'b00100;
        tick();
        b.done = '0;
        chk("single_gap_gnt", int'(b.gnt), 0);
        chk("single_gap_busy", int'(b.busy), 1);
        b.req = '0;
        tick();
        chk("single_idle_busy", int'(b.busy), 0);

        // full contention fairness, each owner holds two cycles
        do_reset();
        b.req = 5'b11111;
        age = 0; gap = 0;
        for (int c = 0; c < 80 && order.size() < 6; c++) begin
            tick();
            if (b.gnt != '0) begin
                if (age == 0) begin
                    order.push_back(int'(b.gnt_idx));
                    if (order.size() > 1) gaps.push_back(gap);
                    gap = 0;
                end
                age++;
                b.done = (age == 2) ? b.gnt : '0;
            end else begin
                age = 0; gap++; b.done = '0;
            end
        end
        b.done = '0;
        chk("fair_count", order.size(), 6);
        packed_order = 0;
        foreach (order[i]) packed_order = packed_order * 8 + order[i];
        chk("fair_order", packed_order, 'o012340);
        foreach (gaps[i]) chk("fair_gap", gaps[i], 2);

        // timeout after MAX_HOLD cycles
        do_reset();
        b.req = 5'b01000;
        hi = 0; to_cnt = 0; to_at_fall = 0; fell = 0;
        for (int c = 0; c < 40 && !fell; c++) begin
            tick();
            if (b.gnt != '0) hi++;
            else if (hi > 0) begin
                fell = 1; to_at_fall = int'(b.timeout);
            end
            if (b.timeout) to_cnt++;
        end
        chk("to_hold_len", hi, 16);
        chk("to_at_fall", to_at_fall, 1);
        tick();
        chk("to_pulse_end", int'(b.timeout), 0);
        chk("to_pulse_count", to_cnt, 1);
        tick();
        chk("to_regrant", int'(b.gnt), 5'b01000);

        // done coincides with hold limit
        do_reset();
        b.req = 5'b01000;
        tick();
        repeat (15) tick();
        chk("coll_gnt_c16", int'(b.gnt), 5'b01000);
        b.done = 5'b01000;
        tick();
        b.done = '0;
        chk("coll_gnt", int'(b.gnt), 0);
        chk("coll_timeout", int'(b.timeout), 0);

        // non-owner done ignored, request drop releases
        do_reset();
        b.req = 5'b00010;
        tick();
        chk("ign_own", int'(b.gnt_idx), 1);
        b.done = 5'b10000;
        tick();
        b.done = '0;
        chk("ign_gnt", int'(b.gnt), 5'b00010);
        b.req = '0;
        tick();
        chk("drop_gnt", int'(b.gnt), 0);

        // asynchronous reset while child 4 owns
        do_reset();
        b.req = 5'b10000;
        tick();
        chk("ar_own", int'(b.gnt_idx), 4);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_gnt", int'(b.gnt), 0);
        chk("ar_busy", int'(b.busy), 0);
        b.req = 5'b10001;
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_first", int'(b.gnt), 5'b00001);

        // random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            if ($urandom_range(7) == 0) b.req = N'($urandom);
            b.done = N'($urandom & $urandom);
            if ($urandom_range(499) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/subtree_rr_arbiter.md
# subtree_rr_arbiter

Round-robin grant controller that shares one downstream resource among the five sibling instances of a generated subtree level (child indices 0..4). Each child raises a request, receives an exclusive one-hot grant, and holds it until it signals done, drops its request, or a hold-time limit expires. The block sits in the parent module alongside the five child instances and is the only source of their grants.

## Interface

Parameters:
- N, 5, number of requesting children (2..8).
- MAX_HOLD, 16, maximum grant cycles per ownership (2..255).
- IDXW, $clog2(N), width of index outputs.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion clears state immediately, deassertion synchronised externally.
- req  input  N  per-child request, level, held until granted.
- done  input  N  per-child release pulse; only the owner's bit is honoured.
- gnt  output  N  one-hot grant, registered; all-zero when no owner.
- gnt_idx  output  IDXW  index of current owner; 0 when gnt is zero.
- busy  output  1  high while in GRANT or GAP.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

## Operation

- States: IDLE, GRANT, GAP. Reset state IDLE.
- Reset values: gnt=0, gnt_idx=0, busy=0, timeout=0, hold counter=0, last-owner pointer=N-1 (so child 0 has highest priority after reset).
- IDLE: if req!=0, select the first set bit scanning from (last+1) mod N upward with wrap; register gnt/gnt_idx, set last=selected, clear counter, go GRANT. If req==0 stay IDLE.
- GRANT: counter increments each cycle (saturating at MAX_HOLD-1; 8-bit counter sufficient). Release condition evaluated each cycle:
  - done[owner]=1, or req[owner]=0 → normal release.
  - else counter==MAX_HOLD-1 → forced release, timeout pulses next cycle.
  - On release: gnt cleared next cycle, go GAP.
- GAP: one turnaround cycle with gnt=0, busy=1; then IDLE. Guarantees no back-to-back grant overlap.
- done bits of non-owners and done while IDLE/GAP are ignored.
- Simultaneous done[owner] and counter limit: normal release, no timeout pulse.
- Requests from non-owners during GRANT are not queued; they are re-sampled in IDLE.
- Requester that keeps req high after release competes again; it has lowest priority in the next scan.

## Timing

- Request-to-grant latency: 1 cycle from IDLE (req high at edge k → gnt at edge k+1).
- Grant duration: 1..MAX_HOLD cycles; a grant never exceeds MAX_HOLD cycles of gnt high.
- Release-to-release: done sampled at edge k → gnt=0 after edge k+1; next grant earliest after edge k+3 (GAP, IDLE, grant).
- Minimum cycle per ownership with continuous contention: grant length + 2.
- timeout high exactly one cycle, aligned with gnt falling.
- Reset mid-grant: gnt, busy, timeout go low asynchronously on rst_n fall; pointer returns to N-1.
- gnt and gnt_idx change only together; gnt is always zero or exactly one bit.

## Test plan

- Single requester: after reset, req=5'b00100 held, done pulse on 3rd grant cycle → gnt=5'b00100 one cycle after req, held 3 cycles, drops, gnt_idx=2 while granted, busy spans grant+GAP.
- Full contention fairness: req=5'b11111 constant, each owner pulses done after 2 cycles → grant order 0,1,2,3,4,0 with exactly 2 idle-grant cycles (GAP, IDLE) between grants.
- Timeout: MAX_HOLD=16, req=5'b01000 held, no done → gnt high exactly 16 cycles, timeout pulses once as gnt falls, then child 3 re-granted after GAP+IDLE.
- Done/limit collision: done[owner] asserted on cycle 16 of grant → release, timeout stays 0.
- Ignored done: owner=1, done=5'b10000 pulsed → grant to child 1 unaffected; drop req[1] → release next cycle.
- Async reset mid-grant: owner=4, assert rst_n=0 mid-cycle → gnt=0 immediately; after release with req=5'b10001, child 0 granted first.
